// File: rtl/orb_input_pkg.sv
// Shared constants and types for the Orbitron input stage: scan codes,
// joystick/CSJUDLR bit positions and the credit sequencer state.
package orb_input_pkg;

   // Direction keys match on the low byte only; the extended bit is ignored.
   localparam logic [7:0] KEY_UP    = 8'h75;
   localparam logic [7:0] KEY_DOWN  = 8'h72;
   localparam logic [7:0] KEY_LEFT  = 8'h6B;
   localparam logic [7:0] KEY_RIGHT = 8'h74;
   localparam logic [8:0] KEY_SPACE = 9'h029;
   localparam logic [8:0] KEY_CTRL  = 9'h014;
   localparam logic [8:0] KEY_F1    = 9'h005;
   localparam logic [8:0] KEY_F2    = 9'h006;

   localparam int unsigned JOY_R    = 0;
   localparam int unsigned JOY_L    = 1;
   localparam int unsigned JOY_D    = 2;
   localparam int unsigned JOY_U    = 3;
   localparam int unsigned JOY_FIRE = 4;
   localparam int unsigned JOY_S1   = 5;
   localparam int unsigned JOY_S2   = 6;

   localparam int unsigned CS_L     = 0;
   localparam int unsigned CS_R     = 1;
   localparam int unsigned CS_D     = 2;
   localparam int unsigned CS_U     = 3;
   localparam int unsigned CS_FIRE  = 4;
   localparam int unsigned CS_START = 5;
   localparam int unsigned CS_COIN  = 6;

   typedef enum logic [1:0] {IDLE, COIN, GAP, START} seq_state_t;

   typedef struct packed {
      logic up;
      logic down;
      logic left;
      logic right;
      logic fire;
      logic s1;
      logic s2;
   } key_state_t;

endpackage

// File: rtl/orb_ps2_key_latch.sv
// PS/2 event detection and held-key latches for the seven mapped keys.
module orb_ps2_key_latch
   import orb_input_pkg::*;
(
   input  logic        clk_i,
   input  logic        rst_ni,
   input  logic [10:0] ps2_key_i,
   input  logic        clear_i,
   output key_state_t  keys_o
);

   logic       tog_q;
   key_state_t keys_q, keys_d;
   logic [8:0] ext_code;
   logic       pressed;

   assign ext_code = ps2_key_i[8:0];
   assign pressed  = ps2_key_i[9];

   always_comb begin
      keys_d = keys_q;
      // A clear wins over an event arriving in the same cycle.
      if (clear_i) begin
         keys_d = '0;
      end else if (ps2_key_i[10] != tog_q) begin
         if (ext_code[7:0] == KEY_UP)    keys_d.up    = pressed;
         if (ext_code[7:0] == KEY_DOWN)  keys_d.down  = pressed;
         if (ext_code[7:0] == KEY_LEFT)  keys_d.left  = pressed;
         if (ext_code[7:0] == KEY_RIGHT) keys_d.right = pressed;
         if (ext_code == KEY_SPACE || ext_code == KEY_CTRL) keys_d.fire = pressed;
         if (ext_code == KEY_F1) keys_d.s1 = pressed;
         if (ext_code == KEY_F2) keys_d.s2 = pressed;
      end
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         tog_q  <= 1'b0;
         keys_q <= '0;
      end else begin
         tog_q  <= ps2_key_i[10];
         keys_q <= keys_d;
      end
   end

   assign keys_o = keys_q;

endmodule

// File: rtl/orb_input_ctrl.sv
// Orbitron input stage: merges keyboard and joysticks, remaps for Horz
// orientation and runs the coin-then-start credit sequencer.
module orb_input_ctrl #(
   parameter int unsigned COIN_CYCLES  = 600000,
   parameter int unsigned GAP_CYCLES   = 600000,
   parameter int unsigned START_CYCLES = 1200000,
   parameter int unsigned CW           = 21
) (
   input  logic        clk_sys,
   input  logic        reset_n,
   input  logic [10:0] ps2_key,
   input  logic [15:0] joystick_0,
   input  logic [15:0] joystick_1,
   input  logic        horz,
   input  logic        clear_keys,
   output logic [6:0]  p1_csjudlr,
   output logic [6:0]  p2_csjudlr,
   output logic        seq_busy
);
   import orb_input_pkg::*;

   localparam logic [CW-1:0] COIN_LAST  = CW'(COIN_CYCLES - 1);
   localparam logic [CW-1:0] GAP_LAST   = CW'(GAP_CYCLES - 1);
   localparam logic [CW-1:0] START_LAST = CW'(START_CYCLES - 1);

   key_state_t keys;
   logic [6:0] joy;
   logic       up, down, left, right, fire, s1, s2;
   logic       unused_joy;

   orb_ps2_key_latch u_key_latch (
      .clk_i     (clk_sys),
      .rst_ni    (reset_n),
      .ps2_key_i (ps2_key),
      .clear_i   (clear_keys),
      .keys_o    (keys)
   );

   assign joy        = joystick_0[6:0] | joystick_1[6:0];
   assign unused_joy = ^{joystick_0[15:7], joystick_1[15:7]};

   always_comb begin
      if (horz) begin
         up    = keys.left  | joy[JOY_L];
         down  = keys.right | joy[JOY_R];
         left  = keys.down  | joy[JOY_D];
         right = keys.up    | joy[JOY_U];
      end else begin
         up    = keys.up    | joy[JOY_U];
         down  = keys.down  | joy[JOY_D];
         left  = keys.left  | joy[JOY_L];
         right = keys.right | joy[JOY_R];
      end
      fire = keys.fire | joy[JOY_FIRE];
      s1   = keys.s1   | joy[JOY_S1];
      s2   = keys.s2   | joy[JOY_S2];
   end

   seq_state_t    state_q, state_d;
   logic [CW-1:0] cnt_q, cnt_d;
   logic [1:0]    coins_q, coins_d;
   logic          which2_q, which2_d;
   logic          s1_q, s2_q;
   logic [6:0]    p1_q, p1_d, p2_q, p2_d;
   logic          busy_q;

   always_comb begin
      state_d  = state_q;
      cnt_d    = cnt_q + 1'b1;
      coins_d  = coins_q;
      which2_d = which2_q;
      unique case (state_q)
         IDLE: begin
            cnt_d = '0;
            // Player 2 wins a same-cycle tie.
            if (s2 && !s2_q) begin
               which2_d = 1'b1;
               coins_d  = 2'd2;
               state_d  = COIN;
            end else if (s1 && !s1_q) begin
               which2_d = 1'b0;
               coins_d  = 2'd1;
               state_d  = COIN;
            end
         end
         COIN: begin
            if (cnt_q == COIN_LAST) begin
               cnt_d   = '0;
               coins_d = coins_q - 2'd1;
               state_d = GAP;
            end
         end
         GAP: begin
            if (cnt_q == GAP_LAST) begin
               cnt_d   = '0;
               state_d = (coins_q != 2'd0) ? COIN : START;
            end
         end
         START: begin
            if (cnt_q == START_LAST) begin
               cnt_d   = '0;
               state_d = IDLE;
            end
         end
      endcase
   end

   always_comb begin
      p1_d           = '0;
      p1_d[CS_COIN]  = (state_d == COIN);
      p1_d[CS_START] = (state_d == START) && !which2_d;
      p1_d[CS_FIRE]  = fire;
      p1_d[CS_R]     = right;
      p1_d[CS_L]     = left;
      // Player 2 panel reuses the up/down pair as its two direction bits.
      p2_d           = '0;
      p2_d[CS_START] = (state_d == START) && which2_d;
      p2_d[CS_FIRE]  = fire;
      p2_d[CS_R]     = up;
      p2_d[CS_L]     = down;
   end

   always_ff @(posedge clk_sys or negedge reset_n) begin
      if (!reset_n) begin
         state_q  <= IDLE;
         cnt_q    <= '0;
         coins_q  <= '0;
         which2_q <= 1'b0;
         s1_q     <= 1'b0;
         s2_q     <= 1'b0;
         p1_q     <= '0;
         p2_q     <= '0;
         busy_q   <= 1'b0;
      end else begin
         state_q  <= state_d;
         cnt_q    <= cnt_d;
         coins_q  <= coins_d;
         which2_q <= which2_d;
         s1_q     <= s1;
         s2_q     <= s2;
         p1_q     <= p1_d;
         p2_q     <= p2_d;
         busy_q   <= (state_d != IDLE);
      end
   end

   assign p1_csjudlr = p1_q;
   assign p2_csjudlr = p2_q;
   assign seq_busy   = busy_q;

endmodule

// File: tb/tb_orb_input_ctrl.sv
// Bench for orb_input_ctrl: directed credit/key scenarios plus random traffic
// compared every cycle against a schedule-queue model of the input stage.
module tb_orb_input_ctrl;
   timeunit 1ns;
   timeprecision 100ps;

   localparam int unsigned COIN_N  = 4;
   localparam int unsigned GAP_N   = 3;
   localparam int unsigned START_N = 5;

   logic        clk        = 1'b0;
   logic        reset_n    = 1'b0;
   logic [10:0] ps2_key    = '0;
   logic [15:0] joystick_0 = '0;
   logic [15:0] joystick_1 = '0;
   logic        horz       = 1'b0;
   logic        clear_keys = 1'b0;
   logic [6:0]  p1_csjudlr, p2_csjudlr;
   logic        seq_busy;

   int checks = 0;
   int errors = 0;

   orb_input_ctrl #(
      .COIN_CYCLES  (COIN_N),
      .GAP_CYCLES   (GAP_N),
      .START_CYCLES (START_N),
      .CW           (8)
   ) dut (
      .clk_sys    (clk),
      .reset_n    (reset_n),
      .ps2_key    (ps2_key),
      .joystick_0 (joystick_0),
      .joystick_1 (joystick_1),
      .horz       (horz),
      .clear_keys (clear_keys),
      .p1_csjudlr (p1_csjudlr),
      .p2_csjudlr (p2_csjudlr),
      .seq_busy   (seq_busy)
   );

   always #5 clk = ~clk;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
      end
   endtask

   // Reference model: held keys, previous start levels, and a queue holding the
   // per-cycle {coin, start1, start2} pattern of the credit currently running.
   logic       k_u = 0, k_d = 0, k_l = 0, k_r = 0, k_f = 0, k_s1 = 0, k_s2 = 0;
   logic       prev_tog = 0, prev_s1 = 0, prev_s2 = 0;
   logic [2:0] sched[$];
   logic [6:0] exp_p1 = '0, exp_p2 = '0;
   logic       exp_busy = 1'b0;

   task automatic push_credit(input int unsigned n);
      for (int c = 0; c < int'(n); c++) begin
         repeat (COIN_N) sched.push_back(3'b100);
         repeat (GAP_N) sched.push_back(3'b000);
      end
      repeat (START_N) sched.push_back((n == 2) ? 3'b001 : 3'b010);
   endtask

   task automatic model_reset();
      {k_u, k_d, k_l, k_r, k_f, k_s1, k_s2} = '0;
      prev_tog = 0; prev_s1 = 0; prev_s2 = 0;
      sched.delete();
      exp_p1 = '0; exp_p2 = '0; exp_busy = 1'b0;
   endtask

   task automatic model_step();
      logic [6:0] j;
      logic       mu, md, ml, mr, mf, ms1, ms2;
      logic [2:0] e;
      logic [8:0] kc;
      j = joystick_0[6:0] | joystick_1[6:0];
      if (!horz) begin
         mu = k_u | j[3]; md = k_d | j[2]; ml = k_l | j[1]; mr = k_r | j[0];
      end else begin
         mu = k_l | j[1]; md = k_r | j[0]; ml = k_d | j[2]; mr = k_u | j[3];
      end
      mf = k_f | j[4]; ms1 = k_s1 | j[5]; ms2 = k_s2 | j[6];
      // A new credit may only start once the previous one is fully off the bus.
      if (!exp_busy && sched.size() == 0) begin
         if (ms2 && !prev_s2) push_credit(2);
         else if (ms1 && !prev_s1) push_credit(1);
      end
      prev_s1 = ms1;
      prev_s2 = ms2;
      e = 3'b000;
      exp_busy = (sched.size() != 0);
      if (exp_busy) e = sched.pop_front();
      exp_p1 = {e[2], e[1], mf, 2'b00, mr, ml};
      exp_p2 = {1'b0, e[0], mf, 2'b00, mu, md};
      kc = ps2_key[8:0];
      if (clear_keys) begin
         {k_u, k_d, k_l, k_r, k_f, k_s1, k_s2} = '0;
      end else if (ps2_key[10] != prev_tog) begin
         if (kc[7:0] == 8'h75) k_u = ps2_key[9];
         if (kc[7:0] == 8'h72) k_d = ps2_key[9];
         if (kc[7:0] == 8'h6B) k_l = ps2_key[9];
         if (kc[7:0] == 8'h74) k_r = ps2_key[9];
         if (kc == 9'h029 || kc == 9'h014) k_f = ps2_key[9];
         if (kc == 9'h005) k_s1 = ps2_key[9];
         if (kc == 9'h006) k_s2 = ps2_key[9];
      end
      prev_tog = ps2_key[10];
   endtask

   initial forever begin
      @(posedge clk or negedge reset_n);
      if (!reset_n) model_reset();
      else model_step();
   end

   initial forever begin
      @(negedge clk);
      check("cmp_p1", 32'(p1_csjudlr), 32'(exp_p1));
      check("cmp_p2", 32'(p2_csjudlr), 32'(exp_p2));
      check("cmp_busy", 32'(seq_busy), 32'(exp_busy));
   end

   task automatic tick(input int n = 1);
      repeat (n) begin
         @(posedge clk);
         @(negedge clk);
      end
   endtask

   task automatic ps2_event(input logic pressed, input logic [8:0] code);
      ps2_key = {~ps2_key[10], pressed, code};
   endtask

   logic [8:0] codes [13] = '{9'h075, 9'h175, 9'h072, 9'h06B, 9'h174, 9'h029, 9'h014,
                              9'h114, 9'h005, 9'h006, 9'h105, 9'h01C, 9'h0FF};

   initial begin
      logic [18:0] coinv, s1v, s2v, busyv;
      int          ncoin, nbusy;
      logic [31:0] r;

      // Reset state
      repeat (3) @(negedge clk);
      check("reset_p1", 32'(p1_csjudlr), 32'h0);
      check("reset_p2", 32'(p2_csjudlr), 32'h0);
      check("reset_busy", 32'(seq_busy), 32'h0);
      reset_n = 1'b1;
      tick(2);

      // Left key: two-cycle latency on press and release
      ps2_event(1'b1, 9'h06B);
      tick(); check("left_press_1cyc", 32'(p1_csjudlr[0]), 32'h0);
      tick(); check("left_press_2cyc", 32'(p1_csjudlr[0]), 32'h1);
      ps2_event(1'b0, 9'h06B);
      tick(); check("left_rel_1cyc", 32'(p1_csjudlr[0]), 32'h1);
      tick(); check("left_rel_2cyc", 32'(p1_csjudlr[0]), 32'h0);

      // Horz remap: joystick up becomes right
      horz = 1'b1;
      joystick_1 = 16'h0008;
      tick(); check("horz_up_to_right", 32'(p1_csjudlr), 32'h02);
      joystick_1 = '0;
      horz = 1'b0;
      tick();

      // Single credit from joystick Start1
      joystick_0 = 16'h0020;
      coinv = '0; s1v = '0; s2v = '0; busyv = '0;
      for (int i = 0; i < 12; i++) begin
         tick();
         coinv[i] = p1_csjudlr[6]; s1v[i] = p1_csjudlr[5];
         s2v[i] = p2_csjudlr[5]; busyv[i] = seq_busy;
      end
      check("single_coin", 32'(coinv), 32'h00F);
      check("single_start1", 32'(s1v), 32'hF80);
      check("single_start2", 32'(s2v), 32'h0);
      check("single_busy", 32'(busyv), 32'hFFF);

      // Held start must not retrigger
      nbusy = 0;
      for (int i = 0; i < 10; i++) begin
         tick();
         nbusy += int'(seq_busy);
      end
      check("held_no_retrigger", 32'(nbusy), 32'h0);
      joystick_0 = '0;
      tick();
      joystick_0 = 16'h0020;
      tick(); check("retrigger_coin", 32'(p1_csjudlr[6]), 32'h1);
      joystick_0 = '0;
      tick();
      joystick_0 = 16'h0020;
      ncoin = 0; nbusy = 0;
      for (int i = 0; i < 20; i++) begin
         tick();
         ncoin += int'(p1_csjudlr[6]);
         nbusy += int'(seq_busy);
      end
      check("edge_in_coin_coins", 32'(ncoin), 32'h2);
      check("edge_in_coin_busy", 32'(nbusy), 32'd10);
      joystick_0 = '0;
      tick(2);

      // Two-player credit from F2 key, then simultaneous joystick starts
      for (int pass = 0; pass < 2; pass++) begin
         if (pass == 0) begin
            ps2_event(1'b1, 9'h006);
            tick();
         end else begin
            joystick_0 = 16'h0060;
         end
         coinv = '0; s1v = '0; s2v = '0; busyv = '0;
         for (int i = 0; i < 19; i++) begin
            tick();
            coinv[i] = p1_csjudlr[6]; s1v[i] = p1_csjudlr[5];
            s2v[i] = p2_csjudlr[5]; busyv[i] = seq_busy;
         end
         check("dual_coin", 32'(coinv), 32'h0078F);
         check("dual_start2", 32'(s2v), 32'h7C000);
         check("dual_start1", 32'(s1v), 32'h0);
         check("dual_busy", 32'(busyv), 32'h7FFFF);
         if (pass == 0) ps2_event(1'b0, 9'h006);
         else joystick_0 = '0;
         tick(3);
      end

      // Async reset in the middle of START
      ps2_event(1'b1, 9'h06B);
      tick(2);
      check("pre_reset_left", 32'(p1_csjudlr[0]), 32'h1);
      ps2_event(1'b1, 9'h000);
      joystick_0 = 16'h0020;
      tick(9);
      check("pre_reset_start", 32'(p1_csjudlr[5]), 32'h1);
      joystick_0 = '0;
      @(posedge clk);
      #2 reset_n = 1'b0;
      #1;
      check("async_p1", 32'(p1_csjudlr), 32'h0);
      check("async_p2", 32'(p2_csjudlr), 32'h0);
      check("async_busy", 32'(seq_busy), 32'h0);
      reset_n = 1'b1;
      @(negedge clk);
      tick(2);
      check("post_reset_p1", 32'(p1_csjudlr), 32'h0);
      check("post_reset_busy", 32'(seq_busy), 32'h0);

      // clear_keys during START drops keys but not the start pulse
      ps2_event(1'b1, 9'h029);
      tick(2);
      check("fire_key", 32'(p1_csjudlr[4]), 32'h1);
      joystick_0 = 16'h0020;
      s1v = '0;
      for (int i = 0; i < 12; i++) begin
         tick();
         s1v[i] = p1_csjudlr[5];
         if (i == 7) clear_keys = 1'b1;
         if (i == 8) clear_keys = 1'b0;
      end
      check("clear_start1", 32'(s1v), 32'hF80);
      check("clear_fire", 32'(p1_csjudlr[4]), 32'h0);
      joystick_0 = '0;
      tick(2);

      // Random traffic against the model
      for (int cyc = 0; cyc < 4000; cyc++) begin
         r = $urandom;
         joystick_0 = (joystick_0 & 16'h0060) | (r[15:0] & 16'hFF9F);
         joystick_1 = (joystick_1 & 16'h0060) | ({r[31:16]} & 16'hFF83);
         if ($urandom_range(0, 29) == 0) joystick_0[5] = ~joystick_0[5];
         if ($urandom_range(0, 59) == 0) joystick_0[6] = ~joystick_0[6];
         if ($urandom_range(0, 59) == 0) joystick_1[5] = ~joystick_1[5];
         if ($urandom_range(0, 59) == 0) joystick_1[6] = ~joystick_1[6];
         if ($urandom_range(0, 3) == 0)
            ps2_event(1'($urandom_range(0, 1)), codes[$urandom_range(0, 12)]);
         clear_keys = ($urandom_range(0, 63) == 0);
         if ($urandom_range(0, 199) == 0) horz = ~horz;
         tick();
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
